// File: rtl/interconn_pkg.sv
// Shared interconnect types, widths and source-decode helpers.
// Used by the receive buffer and its FIFO.
package interconn_pkg;

    localparam int INTERCONN_N     = 8;
    localparam int INTERCONN_W     = 1024;
    localparam int INTERCONN_BADDR = 15;
    localparam int INTERCONN_SW    = $clog2(INTERCONN_N);

    typedef struct packed {
        logic [INTERCONN_SW-1:0]    src;
        logic [INTERCONN_BADDR-1:0] addr;
        logic [INTERCONN_W-1:0]     word;
    } rx_entry_t;

    function automatic logic is_onehot(
        input logic [INTERCONN_N-1:0] v
    );
        return (v != '0) &&
               ((v & (v - INTERCONN_N'(1))) == '0);
    endfunction

    function automatic logic [INTERCONN_SW-1:0] onehot_to_idx(
        input logic [INTERCONN_N-1:0] v
    );
        logic [INTERCONN_SW-1:0] idx;
        idx = '0;
        for (int i = 0; i < INTERCONN_N; i++) begin
            if (v[i]) begin
                idx = idx | INTERCONN_SW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interconn_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Caller must never push when full without a pop.
module interconn_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  logic [DW-1:0]          wr_data,
    input  logic                   pop,
    output logic [DW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LW'(DEPTH));

    // Storage array; no reset needed, validity is tracked by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: moves only when exactly one of push/pop fires.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/interconn_rxbuf.sv
// Per-MVU receive buffer: queues remote beats and writes them
// to data memory in cycles the local MVU leaves the port free.
module interconn_rxbuf
    import interconn_pkg::*;
#(
    parameter int N     = INTERCONN_N,
    parameter int W     = INTERCONN_W,
    parameter int BADDR = INTERCONN_BADDR,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N-1:0]           recv_from,
    input  logic                   recv_en,
    input  logic [BADDR-1:0]       recv_addr,
    input  logic [W-1:0]           recv_word,
    input  logic [N-1:0]           src_mask,
    input  logic                   loc_wr_en,
    output logic                   mem_wr_en,
    output logic [BADDR-1:0]       mem_wr_addr,
    output logic [W-1:0]           mem_wr_word,
    output logic [$clog2(N)-1:0]   mem_wr_src,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   rej,
    output logic [CNTW-1:0]        drop_cnt,
    input  logic                   stat_clr
);

    rx_entry_t wr_ent;
    rx_entry_t head;

    logic valid_src;
    logic push_req;
    logic pop;
    logic push;
    logic full;
    logic rej_ev;
    logic ovf_ev;
    logic drop_ev;

    assign valid_src = is_onehot(recv_from) &&
                       ((recv_from & src_mask) != '0);
    assign push_req  = recv_en & valid_src;
    assign rej_ev    = recv_en & ~valid_src;
    assign pop       = (level != '0) & ~loc_wr_en;
    assign push      = push_req & (~full | pop);
    assign ovf_ev    = push_req & full & ~pop;
    assign drop_ev   = rej_ev | ovf_ev;

    assign wr_ent.src  = onehot_to_idx(recv_from);
    assign wr_ent.addr = recv_addr;
    assign wr_ent.word = recv_word;

    interconn_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(rx_entry_t))
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .push    (push),
        .wr_data (wr_ent),
        .pop     (pop),
        .rd_data (head),
        .level   (level),
        .full    (full)
    );

    // Memory write register: strobe on pop, data holds otherwise.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_word <= '0;
            mem_wr_src  <= '0;
        end else begin
            mem_wr_en <= pop;
            if (pop) begin
                mem_wr_addr <= head.addr;
                mem_wr_word <= head.word;
                mem_wr_src  <= head.src;
            end
        end
    end

    // Sticky drop flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ovf <= 1'b0;
            rej <= 1'b0;
        end else if (stat_clr) begin
            ovf <= 1'b0;
            rej <= 1'b0;
        end else begin
            if (ovf_ev) ovf <= 1'b1;
            if (rej_ev) rej <= 1'b1;
        end
    end

    // Saturating count of every dropped beat.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            drop_cnt <= '0;
        end else if (stat_clr) begin
            drop_cnt <= '0;
        end else if (drop_ev && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_interconn_rxbuf.sv
// Scoreboard bench for interconn_rxbuf.
// Directed beats; a monitor checks every memory write in order.
module tb_interconn_rxbuf;

    localparam int N     = 8;
    localparam int W     = 1024;
    localparam int BADDR = 15;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;

    typedef struct {
        logic [BADDR-1:0] addr;
        logic [W-1:0]     word;
        logic [2:0]       src;
    } exp_t;

    logic             clk = 1'b0;
    logic             clr;
    logic [N-1:0]     recv_from;
    logic             recv_en;
    logic [BADDR-1:0] recv_addr;
    logic [W-1:0]     recv_word;
    logic [N-1:0]     src_mask;
    logic             loc_wr_en;
    logic             mem_wr_en;
    logic [BADDR-1:0] mem_wr_addr;
    logic [W-1:0]     mem_wr_word;
    logic [2:0]       mem_wr_src;
    logic [2:0]       level;
    logic             ovf;
    logic             rej;
    logic [CNTW-1:0]  drop_cnt;
    logic             stat_clr;

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    interconn_rxbuf #(
        .N(N), .W(W), .BADDR(BADDR), .DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .clk(clk), .clr(clr),
        .recv_from(recv_from), .recv_en(recv_en),
        .recv_addr(recv_addr), .recv_word(recv_word),
        .src_mask(src_mask), .loc_wr_en(loc_wr_en),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_word(mem_wr_word), .mem_wr_src(mem_wr_src),
        .level(level), .ovf(ovf), .rej(rej),
        .drop_cnt(drop_cnt), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected beat.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: addr %0h, none expected",
                         mem_wr_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                chk("wr_src", 64'(mem_wr_src), 64'(e.src));
                tests++;
                if (mem_wr_word !== e.word) begin
                    failed++;
                    $display("FAIL wr_word: got %0h expected %0h",
                             mem_wr_word[63:0], e.word[63:0]);
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] from, input logic [BADDR-1:0] a,
                       input logic [63:0] w, input logic loc,
                       input logic acc, input logic [2:0] src);
        exp_t e;
        recv_from = from;
        recv_en   = 1'b1;
        recv_addr = a;
        recv_word = W'(w);
        loc_wr_en = loc;
        if (acc) begin
            e.addr = a;
            e.word = W'(w);
            e.src  = src;
            sb.push_back(e);
        end
        @(negedge clk);
        recv_en = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c;
        recv_en   = 1'b0;
        loc_wr_en = 1'b0;
        c = 0;
        while ((sb.size() != 0 || level != 0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr       = 1'b0;
        recv_from = '0;
        recv_en   = 1'b0;
        recv_addr = '0;
        recv_word = '0;
        src_mask  = 8'hFF;
        loc_wr_en = 1'b0;
        stat_clr  = 1'b0;

        @(negedge clk);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_flags", 64'({ovf, rej}), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        clr = 1'b1;
        @(negedge clk);

        // basic path and two-edge latency
        cyc(8'b0000_0100, 15'd7, 64'hdeadbeefdeadbeef, 1'b0, 1'b1, 3'd2);
        chk("lat_early", 64'(mem_wr_en), 64'd0);
        chk("lat_level", 64'(level), 64'd1);
        @(negedge clk);
        chk("lat_write", 64'(mem_wr_en), 64'd1);
        @(negedge clk);
        chk("one_cycle", 64'(mem_wr_en), 64'd0);

        // local priority holds the FIFO
        for (int i = 0; i < 4; i++)
            cyc(8'b0000_0010, 15'(i), 64'(100 + i), 1'b1, 1'b1, 3'd1);
        recv_en = 1'b0;
        @(negedge clk);
        chk("hold_level", 64'(level), 64'd4);
        chk("hold_no_wr", 64'(mem_wr_en), 64'd0);
        loc_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_wr_en", 64'(mem_wr_en), 64'd1);
        end
        @(negedge clk);
        chk("burst_end", 64'(mem_wr_en), 64'd0);
        chk("burst_level", 64'(level), 64'd0);

        // full with simultaneous pop accepts the beat
        for (int i = 0; i < 4; i++)
            cyc(8'h80, 15'(10 + i), 64'(200 + i), 1'b1, 1'b1, 3'd7);
        cyc(8'h80, 15'd14, 64'd214, 1'b0, 1'b1, 3'd7);
        chk("fullpop_level", 64'(level), 64'd4);
        chk("fullpop_ovf", 64'(ovf), 64'd0);
        chk("fullpop_wr", 64'(mem_wr_en), 64'd1);
        drain(20);

        // overflow drops beats 4 and 5
        for (int i = 0; i < 6; i++)
            cyc(8'h08, 15'(20 + i), 64'(300 + i), 1'b1, i < 4, 3'd3);
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_rej", 64'(rej), 64'd0);
        drain(20);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // asynchronous reset mid-stream discards queued beats
        for (int i = 0; i < 3; i++)
            cyc(8'h20, 15'(40 + i), 64'(400 + i), 1'b1, 1'b1, 3'd5);
        loc_wr_en = 1'b0;
        @(negedge clk);
        chk("pre_rst_wr", 64'(mem_wr_en), 64'd1);
        chk("pre_rst_lvl", 64'(level), 64'd2);
        #2 clr = 1'b0;
        #1;
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("arst_addr", 64'(mem_wr_addr), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        sb.delete();
        @(negedge clk);
        clr = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_lvl", 64'(level), 64'd0);

        // rejects: masked source, then non-one-hot source
        src_mask = 8'hFE;
        cyc(8'h01, 15'd50, 64'd500, 1'b0, 1'b0, 3'd0);
        src_mask = 8'hFF;
        cyc(8'h03, 15'd51, 64'd501, 1'b0, 1'b0, 3'd0);
        chk("rej_flag", 64'(rej), 64'd1);
        chk("rej_drop", 64'(drop_cnt), 64'd2);
        chk("rej_ovf", 64'(ovf), 64'd0);
        chk("rej_level", 64'(level), 64'd0);

        // stat_clr beats a same-cycle reject, leaves FIFO alone
        stat_clr = 1'b1;
        cyc(8'h00, 15'd52, 64'd502, 1'b1, 1'b0, 3'd0);
        stat_clr = 1'b0;
        chk("sclr_rej", 64'(rej), 64'd0);
        chk("sclr_drop", 64'(drop_cnt), 64'd0);
        stat_clr = 1'b1;
        cyc(8'h40, 15'd53, 64'd503, 1'b1, 1'b1, 3'd6);
        stat_clr = 1'b0;
        chk("sclr_fifo", 64'(level), 64'd1);
        drain(10);

        // drop counter saturates
        for (int i = 0; i < 260; i++)
            cyc(8'h00, 15'd0, 64'd0, 1'b0, 1'b0, 3'd0);
        chk("drop_sat", 64'(drop_cnt), 64'd255);
        chk("sat_rej", 64'(rej), 64'd1);

        drain(10);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/interconn_rxbuf.md
Name: interconn_rxbuf

Overview:
- Per-MVU receive buffer placed directly downstream of one receive slice of the interconnect.
- Captures `recv_*` beats in a small FIFO and writes them into the MVU data-memory write port.
- The MVU's own local writes have priority; remote beats drain only in cycles the port is free.
- Tracks sticky overflow and source-reject status, plus saturating drop counters.

Parameters:
- N, 8: number of MVUs (width of `recv_from`, `src_mask`).
- W, 1024: data word width.
- BADDR, 15: memory address width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNTW, 8: drop-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-low reset.
- recv_from  in  N  one-hot source MVU of the current beat.
- recv_en  in  1  beat valid (single-cycle strobe, no backpressure).
- recv_addr  in  BADDR  target memory address.
- recv_word  in  W  data.
- src_mask  in  N  bit i=1: accept beats from MVU i.
- loc_wr_en  in  1  local MVU writes memory this cycle (priority).
- mem_wr_en  out  1  remote write strobe to data memory.
- mem_wr_addr  out  BADDR  write address.
- mem_wr_word  out  W  write data.
- mem_wr_src  out  $clog2(N)  source index of written beat.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky: beat dropped because FIFO full.
- rej  out  1  sticky: beat dropped (masked or non-one-hot source).
- drop_cnt  out  CNTW  saturating count of all dropped beats.
- stat_clr  in  1  synchronous clear of `ovf`, `rej`, `drop_cnt`.

Behaviour:
- Reset (`clr`=0, asynchronous):
  - FIFO pointers, `level` = 0.
  - `mem_wr_en`, `mem_wr_addr`, `mem_wr_word`, `mem_wr_src` = 0.
  - `ovf` = `rej` = 0, `drop_cnt` = 0.
  - Entries in flight are discarded. Outputs are 0 from reset assertion until the first edge after release.
- Beat qualification (combinational):
  - `valid_src` = `recv_from` is exactly one-hot AND `(recv_from & src_mask) != 0`.
  - `push_req` = `recv_en & valid_src`.
  - `recv_en & !valid_src` is a reject: the beat is dropped, `rej` is set, `drop_cnt` increments.
- Pop:
  - `pop` = `(level != 0) & !loc_wr_en`.
  - At most one pop per cycle.
- Push:
  - Accepted when `push_req & ((level < DEPTH) | pop)`. A push while full with a simultaneous pop is accepted.
  - `push_req` while full with no pop is an overflow: the beat is dropped, `ovf` is set, `drop_cnt` increments.
- Stored entry: {src index (binary-encoded `recv_from`), `recv_addr`, `recv_word`}.
- Output register:
  - On the edge where `pop`=1: `mem_wr_en`←1, and `mem_wr_addr`/`mem_wr_word`/`mem_wr_src`←head entry.
  - Otherwise `mem_wr_en`←0 and the data outputs hold their previous value.
- Latency: a beat with `recv_en` sampled at edge k (FIFO empty, `loc_wr_en`=0 in cycle k..k+1) appears with `mem_wr_en`=1 after edge k+1. Minimum latency is 2 edges.
- Throughput: 1 beat/cycle sustained while `loc_wr_en`=0.
- While `loc_wr_en`=1 the FIFO holds; no `mem_wr_en` is issued in the following cycle.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH; a full/empty distinction is made via `level`.
- `level` updates: +1 on push only, −1 on pop only, unchanged on both or neither.
- `drop_cnt` saturates at 2^CNTW−1.
- `stat_clr`:
  - Takes priority over a set/increment in the same cycle.
  - Does not affect the FIFO.

Decomposition:
- Package `interconn_pkg`:
  - `rx_entry_t` struct parameterised via localparams {src, addr, word}.
  - Constants `INTERCONN_N`, `INTERCONN_W`, `INTERCONN_BADDR` shared with `interconn`.
  - Function `onehot_to_idx` and function `is_onehot`.
- Sub-module `interconn_fifo`:
  - Generic synchronous FIFO (`DEPTH`, `DW`) with push, pop, `level` and `full`.
  - Asynchronous active-low `clr`.
  - No overflow logic inside; overflow handling stays in `interconn_rxbuf`.

Test Plan:
- Reset: `clr`=0 mid-stream with 3 entries queued → `level`=0, `mem_wr_en`=0, `ovf`=0 immediately; after release, no stale writes.
- Basic path: `recv_en` with `recv_from`=8'b0000_0100, `addr`=7, `word`=0xdeadbeefdeadbeef, `src_mask`=8'hFF → two edges later `mem_wr_en`=1, `addr`=7, `word` matches, `mem_wr_src`=2, for one cycle.
- Priority: hold `loc_wr_en`=1 and push 4 beats (addr 0..3) → `level`=4, no `mem_wr_en`. Release → addr 0,1,2,3 on 4 consecutive cycles.
- Overflow: `loc_wr_en`=1, push 6 beats with DEPTH=4 → `level`=4, `ovf`=1, `drop_cnt`=2. Drained data is beats 0..3.
- Full with simultaneous pop: `level`=4, deassert `loc_wr_en` and push in the same cycle → accepted, `level` stays 4, `ovf` stays 0.
- Reject: `src_mask`=8'hFE with beat from MVU 0, then `recv_from`=8'b0000_0011 → both dropped, `rej`=1, `drop_cnt`=2. `stat_clr` pulse → all status returns to 0.
